product_bcd_display: RTL and testbench
======================================

// Module: product_bcd_display
// PURPOSE
//  Downstream consumer of the 4x4 array multiplier.
//  - Captures the 8-bit product M on a load pulse.
//  - Converts it to 3-digit BCD with a sequential shift-add-3 (double dabble) engine.
//  - Time-multiplexes the result onto the board's active-low 7-segment display.
//  - The display shows only completed conversions, never partial ones.
// PARAMETERS
//  WIDTH        8       binary input width; number of shift cycles per conversion
//  DIGITS       3       BCD digits converted and scanned (an[3] unused, held 1)
//  REFRESH_CNT  100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); must be >=2
// PORTS
//  clk    in   1         system clock, all logic on rising edge
//  rst    in   1         synchronous, active-high reset
//  M      in   WIDTH     product from csa_multiplier (combinational, stable when load=1)
//  load   in   1         1-cycle request: capture M and start conversion
//  busy   out  1         1 while a conversion is in progress
//  done   out  1         1-cycle pulse: bcd has just been updated
//  bcd    out  4*DIGITS  latched result {hundreds,tens,units}
//  seg    out  7         {g,f,e,d,c,b,a}, active low
//  an     out  4         digit enables, active low; an[0] = units
// BEHAVIOUR
//  - Reset (rst=1 at an edge):
//    - state=IDLE; busy=0; done=0; bcd=0.
//    - Refresh counter=0; digit index=0; an=4'b1111; seg=7'b1111111.
//    - Reset mid-conversion aborts the conversion; no done pulse is issued.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE:
//      - On load=1, capture M into the shift register and clear the BCD scratch.
//      - Set bit counter=0 and busy=1, then go to SHIFT.
//      - With load=0, remain in IDLE.
//    - SHIFT (one bit per cycle):
//      - Add 3 to every scratch nibble >=5.
//      - Shift {scratch,shreg} left by 1.
//      - After the WIDTH-th shift, go to DONE.
//    - DONE (one cycle):
//      - Assert done=1 and drop busy to 0.
//      - Return to IDLE.
//  - bcd update: bcd<=scratch on the same edge at which done rises.
//  - Latency: load sampled at edge T; done=1 and new bcd visible after edge T+WIDTH+1 (T+9 by default).
//  - A new load is accepted in the cycle done=1; back-to-back throughput is WIDTH+2 cycles.
//  - load while busy=1 is ignored; the in-flight conversion is unaffected.
//  - bcd holds its value between conversions.
//  - Width rule: input max 225 (15*15); 255 fits in 3 BCD digits, so no overflow detection.
//  - Scan:
//    - Refresh counter counts 0..REFRESH_CNT-1 and wraps.
//    - On wrap, digit index advances 0,1,..,DIGITS-1, then back to 0.
//    - an has a single 0 at bit [index]; bits >=DIGITS are always 1.
//    - seg = 7-seg decode of bcd nibble [index]. Codes: 0=7'b1000000 ... 9=7'b0010000.
//    - Non-decimal nibbles (unreachable) decode to blank 7'b1111111.
//    - seg and an are registered and change together, one cycle after the index changes.
// CONFIGURATION
//  - Optional macro: LEADING_ZERO_BLANK_EN.
//  - Defined:
//    - Any zero digit above the most significant non-zero digit shows blank (seg=7'b1111111).
//    - Its an bit still scans.
//    - Units digit is never blanked, so 0 shows as a single '0'.
//  - Undefined: all DIGITS digits are always shown, including leading zeros.
// TESTING
//  - Run with REFRESH_CNT=4.
//  1. rst held 2 cycles -> busy=0, done=0, bcd=12'h000, an=4'b1111, seg=7'h7F.
//  2. M=8'd225, load pulse -> busy=1 for cycles T+1..T+8; done=1 at T+9 only; bcd=12'h225.
//  3. M=8'd0, load -> bcd=12'h000, done after 9 cycles.
//     Then M=8'd9, load, and 3 cycles later M=8'd200, load -> second load ignored; bcd=12'h009.
//  4. M=8'd144, load; rst=1 at T+4 -> busy=0, done never pulses, bcd=12'h000.
//     Then a fresh load of 144 -> bcd=12'h144.
//  5. After bcd=12'h225 -> an steps 1110,1101,1011 every 4 cycles and wraps.
//     seg steps 7'b0010010 ('5'), 7'b0100100 ('2'), 7'b0100100 ('2').
//  6. LEADING_ZERO_BLANK_EN defined, M=8'd7 -> hundreds/tens seg=7'b1111111, units seg=7'b1111000.
//     M=8'd0 -> units '0' shown, others blank.
//     Macro undefined -> M=8'd7 shows '0','0','7'.

Source files
------------

// File: rtl/product_bcd_display.sv
// product_bcd_display
//  Captures an 8-bit product on a load pulse and converts it to BCD with a
//  sequential shift-add-3 (double dabble) engine. It then scans the latched
//  result onto an active-low, multiplexed 7-segment display.
//  Optional macro LEADING_ZERO_BLANK_EN: blanks leading zero digits. The units
//  digit is never blanked. When the macro is undefined, every digit is shown.
module product_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_CNT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    M,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [6:0]          seg,
  output logic [3:0]          an
);

  localparam int BW    = 4 * DIGITS;
  localparam int CW    = $clog2(REFRESH_CNT);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW    = $clog2(WIDTH + 1);
  localparam int NSLOT = 1 << IW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]   scratch_reg, scratch_next, scratch_adj;
  logic [NW-1:0]   bitcnt_reg, bitcnt_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [BW-1:0]   bcd_reg, bcd_next;

  logic [CW-1:0]   cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic [6:0]      seg_reg, seg_next;
  logic [3:0]      an_reg, an_next;
  logic [3:0]      nib [NSLOT];
  logic [NSLOT-1:0] lz;

  // 7-segment decode, {g,f,e,d,c,b,a}, active low; non-decimal codes are blank
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction: any scratch nibble >= 5 would overflow past 9 when doubled
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                      scratch_reg[4*gi +: 4] + 4'd3 :
                                      scratch_reg[4*gi +: 4];
    end
  endgenerate

  // Conversion FSM next-state logic; done/busy/bcd are registered outputs
  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    scratch_next = scratch_reg;
    bitcnt_next  = bitcnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    bcd_next     = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          shreg_next   = M;
          scratch_next = '0;
          bitcnt_next  = '0;
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, shreg_next} = {scratch_adj, shreg_reg} << 1;
        bitcnt_next = bitcnt_reg + 1'b1;
        if (bitcnt_reg == NW'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Only a completed conversion reaches bcd, so the display never shows partial results
        done_next  = 1'b1;
        busy_next  = 1'b0;
        bcd_next   = scratch_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion state registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      scratch_reg <= '0;
      bitcnt_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bcd_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      scratch_reg <= scratch_next;
      bitcnt_reg  <= bitcnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      bcd_reg     <= bcd_next;
    end
  end

  // Per-slot digit and leading-zero flag. Slots beyond DIGITS are padded so
  // the index never selects an undefined entry.
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < DIGITS) begin : g_real
        assign nib[gi] = bcd_reg[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (gi == 0) begin : g_units
          assign lz[gi] = 1'b0;
        end else begin : g_upper
          assign lz[gi] = (bcd_reg[BW-1:4*gi] == '0);
        end
`else
        assign lz[gi] = 1'b0;
`endif
      end else begin : g_pad
        assign nib[gi] = 4'hF;
        assign lz[gi]  = 1'b1;
      end
    end
  endgenerate

  // Anode pattern: a single low bit at the scanned digit; unused positions stay high
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      if (gi < DIGITS) begin : g_used
        assign an_next[gi] = (idx_reg != IW'(gi));
      end else begin : g_unused
        assign an_next[gi] = 1'b1;
      end
    end
  endgenerate

  // Segment pattern for the digit currently being scanned
  always_comb begin
    seg_next = seg_decode(nib[idx_reg]);
    if (lz[idx_reg]) begin
      seg_next = 7'b1111111;
    end
  end

  // Refresh timer and digit index; seg/an are registered together from the index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      seg_reg <= 7'b1111111;
      an_reg  <= 4'b1111;
    end else begin
      if (cnt_reg == CW'(REFRESH_CNT - 1)) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign seg  = seg_reg;
  assign an   = an_reg;

endmodule

// File: tb/tb_product_bcd_display.sv
// Testbench for product_bcd_display (REFRESH_CNT=4).
//  A transaction-level reference model predicts busy, done, bcd and the scan.
//  Checks run every cycle, and directed checks cover the main scenarios.
//  Honors LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_product_bcd_display;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int R      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  M;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  product_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_CNT(R)) dut (
    .clk(clk), .rst(rst), .M(M), .load(load),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an)
  );

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scan model: after the k-th non-reset edge, the display shows digit ((k-1)/R) mod DIGITS
  function automatic logic [3:0] exp_an(input int prev_edges);
    int idx = (prev_edges / R) % DIGITS;
    return 4'hF & ~(4'(1) << idx);
  endfunction

  function automatic logic [6:0] exp_seg(input int prev_edges, input int num);
    int idx = (prev_edges / R) % DIGITS;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && num < pow10(idx)) return 7'b1111111;
`endif
    return seg_of((num / pow10(idx)) % 10);
  endfunction

  // Reference model: a conversion completes WIDTH+1 edges after the load is accepted
  int         m_cyc, m_left, m_num, m_val;
  logic       m_done;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  bit         m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_cyc  <= 0;
      m_left <= 0;
      m_num  <= 0;
      m_done <= 1'b0;
      e_an   <= 4'hF;
      e_seg  <= 7'h7F;
    end else begin
      e_an   <= exp_an(m_cyc);
      e_seg  <= exp_seg(m_cyc, m_num);
      m_cyc  <= m_cyc + 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_num <= m_val;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (load) begin
        m_left <= WIDTH + 1;
        m_val  <= int'(M);
      end
    end
  end

  // Continuous comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 16'(busy), 16'(m_left != 0));
      chk("done", 16'(done), 16'(m_done));
      chk("bcd",  16'(bcd),  16'(to_bcd(m_num)));
      chk("an",   16'(an),   16'(e_an));
      chk("seg",  16'(seg),  16'(e_seg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    M    = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int ndone;

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    M    = 8'd0;
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_bcd",  16'(bcd),  16'h000);
    chk("rst_an",   16'(an),   16'hF);
    chk("rst_seg",  16'(seg),  16'h7F);
    rst = 1'b0;
    tick();

    // 225: exact busy/done timing relative to the sampling edge T
    pulse(8'd225);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("lat_busy", 16'(busy), 16'(k <= 8));
      chk("lat_done", 16'(done), 16'(k == 9));
    end
    chk("bcd_225", 16'(bcd), 16'h225);

    // Scan through two full rotations while 225 is held
    repeat (2 * R * DIGITS) tick();

    // 0, then 9 with a second load ignored while busy
    pulse(8'd0);
    repeat (10) tick();
    chk("bcd_000", 16'(bcd), 16'h000);
    pulse(8'd9);
    repeat (2) tick();
    pulse(8'd200);
    repeat (10) tick();
    chk("bcd_009", 16'(bcd), 16'h009);

    // Reset during a conversion aborts it without a done pulse
    pulse(8'd144);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_done", 16'(ndone), 16'd0);
    chk("abort_bcd",  16'(bcd),   16'h000);
    pulse(8'd144);
    repeat (10) tick();
    chk("bcd_144", 16'(bcd), 16'h144);

    // Small values exercise the leading-digit handling across a full scan
    pulse(8'd7);
    repeat (10 + 2 * R * DIGITS) tick();
    chk("bcd_007", 16'(bcd), 16'h007);
    pulse(8'd0);
    repeat (10 + 2 * R * DIGITS) tick();

    // Randomized loads, including loads while busy and occasional resets
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (r < 35) begin
        pulse(8'($urandom_range(0, 255)));
      end else begin
        M = 8'($urandom_range(0, 255));
        tick();
      end
    end
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
